// File: rtl/seg_hex595_scan_if.sv
// -----------------------------------------------------------------------------
// seg_hex595_scan_if
// Purpose : Bundles the control inputs and the 74HC595 chain outputs of the
//           hex display scanner so they travel as one port.
// Signals : en         scan enable
//           data       4*DIGITS bits, nibble i = hex value of digit i
//           dp         DIGITS bits, decimal point per digit (1 = lit)
//           lz_blank   1 = suppress leading zeros
//           hex_clk    595 shift clock
//           hex_dat    595 serial data
//           hex_str    595 storage strobe
//           frame_done one-cycle pulse after the last digit's hold
// Modports: master drives the controls and observes the chain (user side),
//           slave is the scanner itself.
// -----------------------------------------------------------------------------
interface seg_hex595_scan_if #(
    parameter int DIGITS = 4
);
    logic                en;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic                lz_blank;
    logic                hex_clk;
    logic                hex_dat;
    logic                hex_str;
    logic                frame_done;

    modport master (
        output en, data, dp, lz_blank,
        input  hex_clk, hex_dat, hex_str, frame_done
    );

    modport slave (
        input  en, data, dp, lz_blank,
        output hex_clk, hex_dat, hex_str, frame_done
    );
endinterface

// File: rtl/seg_hex595_scan.sv
// -----------------------------------------------------------------------------
// seg_hex595_scan
// Purpose : Drives a multiplexed hex 7-segment display through a 74HC595
//           chain. For each digit a 16-bit word {segment byte, select byte}
//           is shifted out MSB first, latched with a strobe and then held for
//           a refresh interval. Supports per-digit decimal points, leading-zero
//           suppression, segment/select polarity and a frame-done pulse.
// Ports   : sys_clk  system clock
//           sys_rst  asynchronous reset, active high
//           bus      seg_hex595_scan_if.slave (controls in, 595 chain out)
// Params  : DIGITS          digits scanned, 1..8
//           CLK_DIV         sys_clk cycles per hex_clk phase (>= 1)
//           REFRESH_DIV     sys_clk hold cycles after each strobe (>= 1)
//           SEG_ACTIVE_LOW  1: segment byte inverted before shifting
//           DIG_ACTIVE_LOW  1: select byte inverted before shifting
// -----------------------------------------------------------------------------
module seg_hex595_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    seg_hex595_scan_if.slave  bus
);

    localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (CLK_DIV > REFRESH_DIV) ? CLK_DIV : REFRESH_DIV;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_STROBE,
        S_HOLD
    } state_t;

    // Segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // State and datapath registers
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_bit;
    logic [DIG_W-1:0]    r_digit;
    logic [15:0]         r_word;
    logic                r_stop;

    // Frame snapshot of the display inputs
    logic [4*DIGITS-1:0] r_snap_data;
    logic [DIGITS-1:0]   r_snap_dp;
    logic                r_snap_lz;

    // Registered 595 outputs
    logic                r_hex_clk;
    logic                r_hex_dat;
    logic                r_hex_str;
    logic                r_frame_done;

    // Next-state values
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [3:0]          w_bit_nxt;
    logic [DIG_W-1:0]    w_digit_nxt;
    logic [15:0]         w_word_nxt;
    logic                w_stop_nxt;
    logic                w_hex_clk_nxt;
    logic                w_hex_dat_nxt;
    logic                w_hex_str_nxt;
    logic                w_frame_done_nxt;

    // Word construction
    logic [4*DIGITS-1:0] w_f_data;
    logic [DIGITS-1:0]   w_f_dp;
    logic                w_f_lz;
    logic [DIGITS-1:0]   w_sup;
    logic [3:0]          w_nib;
    logic [7:0]          w_seg;
    logic [7:0]          w_sel;
    logic [15:0]         w_load_word;
    logic                w_phase_end;
    logic                w_hold_end;
    logic                w_continue;

    // Digit 0 is loaded in the same cycle the snapshot is taken, so it reads
    // the live inputs; every later digit of the frame reads the snapshot.
    assign w_f_data = (r_digit == '0) ? bus.data     : r_snap_data;
    assign w_f_dp   = (r_digit == '0) ? bus.dp       : r_snap_dp;
    assign w_f_lz   = (r_digit == '0) ? bus.lz_blank : r_snap_lz;

    // Leading-zero run from the top digit down; digit 0 is never part of it
    // and a lit decimal point breaks the run.
    always_comb begin
        logic run;
        w_sup = '0;
        run   = w_f_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run      = run && (w_f_data[4*i +: 4] == 4'h0) && !w_f_dp[i];
            w_sup[i] = run;
        end
    end

    assign w_nib = w_f_data[{r_digit, 2'b00} +: 4];

    always_comb begin
        logic [7:0] seg_raw;
        logic [7:0] sel_raw;
        seg_raw = w_sup[r_digit] ? 8'h00 : {w_f_dp[r_digit], hex_font(w_nib)};
        // Only the current digit's select bit is set; bits >= DIGITS stay 0.
        sel_raw = 8'h01 << r_digit;
        w_seg   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        w_sel   = DIG_ACTIVE_LOW ? ~sel_raw : sel_raw;
    end

    assign w_load_word = {w_seg, w_sel};
    assign w_phase_end = (r_cnt == PHASE_LAST);
    assign w_hold_end  = (r_cnt == HOLD_LAST);
    // Once en has been seen low during a digit, the scan stops after its hold
    // even if en comes back before the hold ends.
    assign w_continue  = bus.en && !r_stop;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 1'b1;
        w_bit_nxt        = r_bit;
        w_digit_nxt      = r_digit;
        w_word_nxt       = r_word;
        w_stop_nxt       = r_stop | ~bus.en;
        w_frame_done_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_stop_nxt  = 1'b0;
                w_digit_nxt = '0;
                if (bus.en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = 4'd0;
                w_word_nxt  = w_load_word;
                w_state_nxt = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (w_phase_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_phase_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 4'd15) begin
                        w_state_nxt = S_STROBE;
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_word_nxt  = {r_word[14:0], 1'b0};
                        w_state_nxt = S_SHIFT_LO;
                    end
                end
            end
            S_STROBE: begin
                if (w_phase_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_hold_end) begin
                    w_cnt_nxt = '0;
                    if (r_digit == DIGIT_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        w_digit_nxt      = '0;
                        w_state_nxt      = w_continue ? S_LOAD : S_IDLE;
                    end else if (w_continue) begin
                        w_digit_nxt = r_digit + 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_digit_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so the 595
        // lines come straight off flops and change in step with the state.
        w_hex_clk_nxt = (w_state_nxt == S_SHIFT_HI);
        w_hex_str_nxt = (w_state_nxt == S_STROBE);
        w_hex_dat_nxt = ((w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI))
                        ? w_word_nxt[15] : 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= 4'd0;
            r_digit      <= '0;
            r_word       <= 16'h0000;
            r_stop       <= 1'b0;
            r_hex_clk    <= 1'b0;
            r_hex_dat    <= 1'b0;
            r_hex_str    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit        <= w_bit_nxt;
            r_digit      <= w_digit_nxt;
            r_word       <= w_word_nxt;
            r_stop       <= w_stop_nxt;
            r_hex_clk    <= w_hex_clk_nxt;
            r_hex_dat    <= w_hex_dat_nxt;
            r_hex_str    <= w_hex_str_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // NOTE: the snapshot is always written before it is read (digit 0 uses
    // the live inputs), so its reset only keeps the power-up state tidy.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_snap_data <= '0;
            r_snap_dp   <= '0;
            r_snap_lz   <= 1'b0;
        end else if ((r_state == S_LOAD) && (r_digit == '0)) begin
            r_snap_data <= bus.data;
            r_snap_dp   <= bus.dp;
            r_snap_lz   <= bus.lz_blank;
        end
    end

    assign bus.hex_clk    = r_hex_clk;
    assign bus.hex_dat    = r_hex_dat;
    assign bus.hex_str    = r_hex_str;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_hex595_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_hex595_scan
// Purpose : Self-checking bench for seg_hex595_scan. Two instances share the
//           stimulus: one with active-low segments/selects, one active-high.
//           A 595 receiver model rebuilds each latched word from hex_clk /
//           hex_dat / hex_str and compares it with a reference computed from
//           the display rules (font table, leading-zero run, select bit).
// -----------------------------------------------------------------------------
module tb_seg_hex595_scan;

    localparam int DIGITS      = 4;
    localparam int CLK_DIV     = 2;
    localparam int REFRESH_DIV = 12;
    localparam int PERIOD      = 1 + 32*CLK_DIV + CLK_DIV + REFRESH_DIV;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        t_en;
    logic [15:0] t_data;
    logic [3:0]  t_dp;
    logic        t_lz;

    seg_hex595_scan_if #(.DIGITS(DIGITS)) ifa ();
    seg_hex595_scan_if #(.DIGITS(DIGITS)) ifb ();

    assign ifa.en       = t_en;
    assign ifa.data     = t_data;
    assign ifa.dp       = t_dp;
    assign ifa.lz_blank = t_lz;
    assign ifb.en       = t_en;
    assign ifb.data     = t_data;
    assign ifb.dp       = t_dp;
    assign ifb.lz_blank = t_lz;

    seg_hex595_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .REFRESH_DIV(REFRESH_DIV),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(ifa)
    );

    seg_hex595_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .REFRESH_DIV(REFRESH_DIV),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) u_dut_ah (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(ifb)
    );

    always #10 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference font {g..a}, digits 0-F.
    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Expected 16-bit word for one digit of a frame.
    function automatic logic [15:0] model_word(input int digit, input logic [15:0] d,
                                               input logic [3:0] p, input logic lz, input bit inv);
        int         nlz;
        bit         in_run;
        logic [7:0] seg;
        logic [7:0] sel;
        nlz    = 0;
        in_run = 1'b1;
        // Count top digits that are 0 without a decimal point (digit 0 excluded).
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (in_run && (d[4*i +: 4] == 4'h0) && !p[i]) nlz++;
            else in_run = 1'b0;
        end
        if (lz && (digit >= DIGITS - nlz)) seg = 8'h00;
        else                               seg = {p[digit], font[d[4*digit +: 4]]};
        sel        = 8'h00;
        sel[digit] = 1'b1;
        if (inv) begin
            seg = ~seg;
            sel = ~sel;
        end
        return {seg, sel};
    endfunction

    // 595 receiver / timing monitor state, one slot per instance.
    logic        p_clk [2];
    logic        p_str [2];
    logic        p_fd  [2];
    logic [15:0] sreg  [2];
    int          rises [2];
    int          run_len [2];
    int          str_len [2];
    int          strobes [2];
    int          fd_cnt  [2];
    int          exp_digit [2];
    int          last_str  [2];
    bit          have_prev [2];
    logic [15:0] snap_data [2];
    logic [3:0]  snap_dp   [2];
    logic        snap_lz   [2];
    logic [15:0] got_word  [2][DIGITS];
    int          cyc = 0;

    task automatic mon(input int k, input logic c, input logic d, input logic s, input logic f);
        logic [15:0] exp;
        if (sys_rst) begin
            sreg[k]      = 16'h0;
            rises[k]     = 0;
            run_len[k]   = 0;
            str_len[k]   = 0;
            exp_digit[k] = 0;
            have_prev[k] = 1'b0;
        end else begin
            if (c != p_clk[k]) begin
                if (c) begin
                    if (k == 0 && rises[k] > 0) check("clk_low_len", run_len[k], CLK_DIV);
                    sreg[k] = {sreg[k][14:0], d};
                    rises[k]++;
                end else if (k == 0) begin
                    check("clk_high_len", run_len[k], CLK_DIV);
                end
                run_len[k] = 1;
            end else begin
                run_len[k]++;
            end

            if (s && !p_str[k]) begin
                if (exp_digit[k] == 0) begin
                    snap_data[k] = t_data;
                    snap_dp[k]   = t_dp;
                    snap_lz[k]   = t_lz;
                end
                exp = model_word(exp_digit[k], snap_data[k], snap_dp[k], snap_lz[k], (k == 0));
                check($sformatf("bits_i%0d_d%0d", k, exp_digit[k]), rises[k], 16);
                check($sformatf("word_i%0d_d%0d", k, exp_digit[k]), sreg[k], exp);
                if (k == 0 && have_prev[k]) check("digit_period", cyc - last_str[k], PERIOD);
                got_word[k][exp_digit[k]] = sreg[k];
                have_prev[k] = 1'b1;
                last_str[k]  = cyc;
                rises[k]     = 0;
                strobes[k]++;
                exp_digit[k] = (exp_digit[k] + 1) % DIGITS;
                str_len[k]   = 1;
            end else if (s) begin
                str_len[k]++;
            end else if (p_str[k] && k == 0) begin
                check("str_len", str_len[k], CLK_DIV);
            end

            if (f) begin
                check($sformatf("fd_width_i%0d", k), p_fd[k], 1'b0);
                check($sformatf("fd_after_last_i%0d", k), exp_digit[k], 0);
                fd_cnt[k]++;
            end
        end
        p_clk[k] = c;
        p_str[k] = s;
        p_fd[k]  = f;
    endtask

    task automatic step();
        @(negedge sys_clk);
        cyc++;
        mon(0, ifa.hex_clk, ifa.hex_dat, ifa.hex_str, ifa.frame_done);
        mon(1, ifb.hex_clk, ifb.hex_dat, ifb.hex_str, ifb.frame_done);
    endtask

    task automatic wait_strobes(input int n);
        int target;
        int budget;
        target = strobes[0] + n;
        budget = (n + 4) * PERIOD;
        while (strobes[0] < target && budget > 0) begin
            step();
            budget--;
        end
        if (strobes[0] < target) check("strobe_timeout", strobes[0], target);
    endtask

    task automatic wait_rises(input int r);
        int budget;
        budget = 2 * PERIOD;
        while (rises[0] < r && budget > 0) begin
            step();
            budget--;
        end
        if (rises[0] < r) check("rise_timeout", rises[0], r);
    endtask

    task automatic resync();
        for (int k = 0; k < 2; k++) begin
            exp_digit[k] = 0;
            have_prev[k] = 1'b0;
        end
    endtask

    initial begin
        int fd_base;
        int str_base;

        for (int k = 0; k < 2; k++) begin
            p_clk[k] = 1'b0; p_str[k] = 1'b0; p_fd[k] = 1'b0;
            sreg[k] = 16'h0; rises[k] = 0; run_len[k] = 0; str_len[k] = 0;
            strobes[k] = 0; fd_cnt[k] = 0; exp_digit[k] = 0; last_str[k] = 0;
            have_prev[k] = 1'b0;
            snap_data[k] = 16'h0; snap_dp[k] = 4'h0; snap_lz[k] = 1'b0;
        end

        sys_rst = 1'b1;
        t_en    = 1'b0;
        t_data  = 16'h0000;
        t_dp    = 4'h0;
        t_lz    = 1'b0;
        repeat (3) step();
        check("rst_hex_clk", ifa.hex_clk, 1'b0);
        check("rst_hex_dat", ifa.hex_dat, 1'b0);
        check("rst_hex_str", ifa.hex_str, 1'b0);
        check("rst_frame_done", ifa.frame_done, 1'b0);

        sys_rst = 1'b0;
        repeat (20) step();
        check("idle_no_strobe", strobes[0], 0);

        // Plain digits 1234, both polarities.
        t_data = 16'h1234;
        t_en   = 1'b1;
        wait_strobes(4);
        check("w1234_d0_al", got_word[0][0], 16'h99FE);
        check("w1234_d1_al", got_word[0][1], 16'hB0FD);
        check("w1234_d2_al", got_word[0][2], 16'hA4FB);
        check("w1234_d3_al", got_word[0][3], 16'hF9F7);
        check("w1234_d0_ah", got_word[1][0], 16'h6601);

        // Leading-zero suppression.
        t_data = 16'h0070;
        t_lz   = 1'b1;
        wait_strobes(4);
        check("lz70_d3", got_word[0][3][15:8], 8'hFF);
        check("lz70_d2", got_word[0][2][15:8], 8'hFF);
        check("lz70_d1", got_word[0][1][15:8], 8'hF8);
        check("lz70_d0", got_word[0][0][15:8], 8'hC0);

        // Decimal point ends the suppressed run.
        t_data = 16'h0000;
        t_dp   = 4'b0100;
        wait_strobes(4);
        check("lzdp_d3", got_word[0][3][15:8], 8'hFF);
        check("lzdp_d2", got_word[0][2][15:8], 8'h40);
        check("lzdp_d1", got_word[0][1][15:8], 8'hC0);
        check("lzdp_d0", got_word[0][0][15:8], 8'hC0);

        // Random frames; inputs change after every strobe, so mid-frame
        // changes must not reach the current frame.
        fd_base = fd_cnt[0];
        for (int n = 0; n < 12 * DIGITS; n++) begin
            t_data = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            t_dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            t_lz   = 1'($urandom_range(0, 1));
            wait_strobes(1);
        end
        repeat (CLK_DIV + REFRESH_DIV + 3) step();
        // Pending pulse from the previous frame plus one per random frame.
        check("frame_done_count", fd_cnt[0] - fd_base, 13);

        // en dropped mid-shift: the digit completes, then the scan idles.
        wait_strobes(1);
        wait_rises(5);
        t_en = 1'b0;
        wait_strobes(1);
        str_base = strobes[0];
        fd_base  = fd_cnt[0];
        repeat (3 * PERIOD) step();
        check("stop_no_strobe", strobes[0], str_base);
        check("stop_no_fd", fd_cnt[0], fd_base);
        check("stop_clk_low", ifa.hex_clk, 1'b0);
        resync();
        t_en = 1'b1;
        wait_strobes(1);

        // en dropped then raised again during the hold: still restarts at digit 0.
        wait_rises(3);
        t_en = 1'b0;
        wait_strobes(1);
        resync();
        repeat (CLK_DIV + 3) step();
        t_en = 1'b1;
        wait_strobes(DIGITS);

        // Reset mid-shift.
        wait_strobes(1);
        wait_rises(7);
        sys_rst = 1'b1;
        step();
        check("midrst_hex_clk", ifa.hex_clk, 1'b0);
        check("midrst_hex_dat", ifa.hex_dat, 1'b0);
        check("midrst_hex_str", ifa.hex_str, 1'b0);
        check("midrst_frame_done", ifa.frame_done, 1'b0);
        sys_rst = 1'b0;
        fd_base = fd_cnt[0];
        wait_strobes(DIGITS);
        repeat (CLK_DIV + REFRESH_DIV + 3) step();
        check("post_rst_frame_done", fd_cnt[0] - fd_base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
